// File: rtl/lsu_split_queue.sv
// Load/store unit front end: issues core accesses as word-aligned bus beats, splitting
// misaligned ones in two, and merges in-order bus responses back into load writebacks.
module lsu_split_queue #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int MISALIGN_SPLIT  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [2:0]  req_width,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        data_req,
  output logic        data_wr,
  input  logic        data_gnt,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_be,
  input  logic [31:0] data_rdata,
  input  logic        data_valid,
  output logic        rsp_valid,
  output logic [4:0]  rsp_rd,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        dbg_state
);
  // Handshakes: a core request completes in the cycle req_valid && req_ready; a bus beat
  // completes in the cycle data_req && data_gnt; data_valid answers the oldest beat.
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);
  localparam bit SPLIT_EN = (MISALIGN_SPLIT != 0);

  typedef enum logic {IDLE = 1'b0, ISSUE2 = 1'b1} state_t;
  typedef struct packed {
    logic [4:0] rd;
    logic [2:0] width;
    logic [1:0] offset;
    logic       load;
    logic       split_first;
    logic       split_second;
  } entry_t;

  state_t        state, state_nxt;
  entry_t        fifo [MAX_OUTSTANDING];
  entry_t        push_entry, head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   hold;
  logic [1:0]    off;
  logic [3:0]    mask;
  logic [7:0]    be_wide;
  logic          misaligned, reject, room, push, pop;
  logic [31:0]   merged, raw;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  assign off = req_addr[1:0];
  always_comb begin
    case (req_width[1:0])
      2'd0:    mask = 4'b0001;
      2'd1:    mask = 4'b0011;
      default: mask = 4'b1111;
    endcase
  end
  // Upper nibble of the shifted mask is exactly the lane set of the second beat.
  assign be_wide    = {4'b0000, mask} << off;
  assign misaligned = (req_width[1:0] == 2'd1 && off == 2'd3) || (req_width[1] && off != 2'd0);
  assign reject     = misaligned && !SPLIT_EN;
  assign head       = fifo[rd_ptr];
  assign pop        = !reset && data_valid && (count != '0);
  assign room       = (count < MAX_C) || pop;

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    data_req   = 1'b0;
    rsp_err    = 1'b0;
    push       = 1'b0;
    data_addr  = {req_addr[31:2], 2'b00};
    data_be    = be_wide[3:0];
    data_wdata = req_wdata << {off, 3'b000};
    push_entry.rd           = req_rd;
    push_entry.width        = req_width;
    push_entry.offset       = off;
    push_entry.load         = !req_wr;
    push_entry.split_first  = 1'b0;
    push_entry.split_second = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (req_valid && reject) begin
            req_ready = 1'b1;
            rsp_err   = 1'b1;
          end else if (req_valid && room) begin
            data_req = 1'b1;
            if (data_gnt) begin
              push = 1'b1;
              if (misaligned) begin
                push_entry.split_first = 1'b1;
                state_nxt = ISSUE2;
              end else begin
                req_ready = 1'b1;
              end
            end
          end
        end
        ISSUE2: begin
          data_addr  = {req_addr[31:2], 2'b00} + 32'd4;
          data_be    = be_wide[7:4];
          data_wdata = req_wdata >> {(3'd4 - {1'b0, off}), 3'b000};
          push_entry.split_second = 1'b1;
          if (room) begin
            data_req = 1'b1;
            if (data_gnt) begin
              push      = 1'b1;
              req_ready = 1'b1;
              state_nxt = IDLE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign data_wr = data_req & req_wr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      hold   <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
        if (head.split_first && head.load) hold <= {data_rdata[31:8], 8'h00};
      end
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= push_entry;
  end

  // Shifting {rdata, hold} right by the offset lines up the bytes of both split halves.
  assign merged = 32'({data_rdata, hold} >> {head.offset, 3'b000});
  assign raw    = head.split_second ? merged : (data_rdata >> {head.offset, 3'b000});

  always_comb begin
    case (head.width[1:0])
      2'd0:    rsp_rdata = head.width[2] ? {24'h0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      2'd1:    rsp_rdata = head.width[2] ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: rsp_rdata = raw;
    endcase
  end

  assign rsp_valid = pop && head.load && !head.split_first;
  assign rsp_rd    = head.rd;
  assign busy      = !reset && ((count != '0) || (state == ISSUE2));
  assign dbg_state = state;
endmodule

// File: tb/tb_lsu_split_queue.sv
// Bench for lsu_split_queue: byte-level memory model, randomized bus slave, scoreboards
// for bus beats and load writebacks, plus a reject-mode instance with MAX_OUTSTANDING=1.
module tb_lsu_split_queue;
  localparam int MAXO = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_wr;
  logic [2:0]  req_width;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        data_req, data_wr, data_gnt, data_valid;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_be;
  logic        rsp_valid, rsp_err, busy, dbg_state;
  logic [4:0]  rsp_rd;
  logic [31:0] rsp_rdata;

  logic        r_req_valid, r_req_ready, r_req_wr;
  logic [2:0]  r_req_width;
  logic [31:0] r_req_addr, r_req_wdata;
  logic [4:0]  r_req_rd;
  logic        r_data_req, r_data_wr, r_data_gnt, r_data_valid;
  logic [31:0] r_data_addr, r_data_wdata, r_data_rdata;
  logic [3:0]  r_data_be;
  logic        r_rsp_valid, r_rsp_err, r_busy, r_dbg_state;
  logic [4:0]  r_rsp_rd;
  logic [31:0] r_rsp_rdata;

  lsu_split_queue #(.MAX_OUTSTANDING(MAXO), .MISALIGN_SPLIT(1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_width(req_width), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .data_req(data_req), .data_wr(data_wr), .data_gnt(data_gnt), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_be(data_be), .data_rdata(data_rdata), .data_valid(data_valid),
    .rsp_valid(rsp_valid), .rsp_rd(rsp_rd), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .dbg_state(dbg_state));

  lsu_split_queue #(.MAX_OUTSTANDING(1), .MISALIGN_SPLIT(0)) u_rej (
    .clk(clk), .reset(reset), .req_valid(r_req_valid), .req_ready(r_req_ready), .req_wr(r_req_wr),
    .req_width(r_req_width), .req_addr(r_req_addr), .req_wdata(r_req_wdata), .req_rd(r_req_rd),
    .data_req(r_data_req), .data_wr(r_data_wr), .data_gnt(r_data_gnt), .data_addr(r_data_addr),
    .data_wdata(r_data_wdata), .data_be(r_data_be), .data_rdata(r_data_rdata),
    .data_valid(r_data_valid), .rsp_valid(r_rsp_valid), .rsp_rd(r_rsp_rd),
    .rsp_rdata(r_rsp_rdata), .rsp_err(r_rsp_err), .busy(r_busy), .dbg_state(r_dbg_state));

  typedef struct { logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; logic wr; } beat_t;
  typedef struct { logic [31:0] rdata; int ready_cyc; } pend_t;

  logic [36:0] exp_q[$];
  beat_t       exp_beat_q[$];
  pend_t       pend_q[$];
  logic [7:0]  ref_mem [logic [31:0]];
  logic [7:0]  bus_mem [logic [31:0]];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit hold_rsp   = 1'b0;
  bit gnt_always = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] w);
    return (w[1:0] == 2'd0) ? 1 : (w[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic logic [7:0] bus_byte(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : 8'h00;
  endfunction

  task automatic set_byte(input logic [31:0] a, input logic [7:0] v);
    ref_mem[a] = v;
    bus_mem[a] = v;
  endtask

  // Reference: an access touches n consecutive bytes; each word touched is one bus beat.
  task automatic push_model(input logic wr, input logic [2:0] width, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [4:0] rd,
                            input bit use_lit, input logic [31:0] lit);
    int n;
    logic [31:0] base, val, a;
    beat_t b0, b1;
    bit two;
    n = nbytes(width);
    base = {addr[31:2], 2'b00};
    b0 = '{base, 4'b0, 32'b0, wr};
    b1 = '{base + 32'd4, 4'b0, 32'b0, wr};
    two = 1'b0;
    for (int i = 0; i < n; i++) begin
      int lane;
      a = addr + 32'(i);
      lane = int'(a[1:0]);
      if ({a[31:2], 2'b00} == base) begin
        b0.be[lane] = 1'b1;
        b0.wdata[8*lane +: 8] = wdata[8*i +: 8];
      end else begin
        two = 1'b1;
        b1.be[lane] = 1'b1;
        b1.wdata[8*lane +: 8] = wdata[8*i +: 8];
      end
    end
    exp_beat_q.push_back(b0);
    if (two) exp_beat_q.push_back(b1);
    if (wr) begin
      for (int i = 0; i < n; i++) ref_mem[addr + 32'(i)] = wdata[8*i +: 8];
    end else begin
      val = 32'h0;
      for (int i = 0; i < n; i++) val[8*i +: 8] = ref_byte(addr + 32'(i));
      if (!width[2] && n < 4 && val[8*n-1]) val = val | ~((32'h1 << (8*n)) - 32'h1);
      exp_q.push_back({rd, use_lit ? lit : val});
    end
  endtask

  // Called just after a falling edge; returns just after the falling edge following acceptance.
  task automatic do_req(input logic wr, input logic [2:0] width, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd,
                        input bit use_lit = 1'b0, input logic [31:0] lit = 32'h0);
    bit ok;
    push_model(wr, width, addr, wdata, rd, use_lit, lit);
    req_valid = 1'b1;
    req_wr    = wr;
    req_width = width;
    req_addr  = addr;
    req_wdata = wdata;
    req_rd    = rd;
    ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin
      #4;
      if (req_ready) ok = 1'b1;
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("req_accept", 64'(ok), 64'd1);
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((exp_q.size() != 0 || pend_q.size() != 0) && c < 400) begin
      @(negedge clk);
      c++;
    end
    check("drain_in_time", 64'(c < 400), 64'd1);
  endtask

  // Bus slave: responds in order after a random delay, grants randomly, checks each beat.
  initial begin
    data_gnt = 1'b0; data_valid = 1'b0; data_rdata = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      data_valid = 1'b0;
      data_rdata = $urandom;
      if (!hold_rsp && pend_q.size() != 0 && cyc >= pend_q[0].ready_cyc) begin
        pend_t p;
        p = pend_q.pop_front();
        data_valid = 1'b1;
        data_rdata = p.rdata;
      end
      #1;
      data_gnt = data_req && (gnt_always || $urandom_range(0, 3) != 0);
      if (data_req) check("inflight_cap", 64'(pend_q.size() < MAXO), 64'd1);
      if (data_req && data_gnt) begin
        pend_t np;
        np.rdata = {bus_byte(data_addr + 32'd3), bus_byte(data_addr + 32'd2),
                    bus_byte(data_addr + 32'd1), bus_byte(data_addr)};
        np.ready_cyc = cyc + 1 + int'($urandom_range(0, 3));
        pend_q.push_back(np);
        if (data_wr) begin
          for (int l = 0; l < 4; l++)
            if (data_be[l]) bus_mem[data_addr + 32'(l)] = data_wdata[8*l +: 8];
        end
        if (exp_beat_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL beat_unexpected: addr %0h be %b, expected no beat", data_addr, data_be);
        end else begin
          beat_t b;
          logic [31:0] m;
          b = exp_beat_q.pop_front();
          m = {{8{b.be[3]}}, {8{b.be[2]}}, {8{b.be[1]}}, {8{b.be[0]}}};
          check("beat_addr", 64'(data_addr), 64'(b.addr));
          check("beat_be", 64'(data_be), 64'(b.be));
          check("beat_wr", 64'(data_wr), 64'(b.wr));
          if (b.wr) check("beat_wdata", 64'(data_wdata & m), 64'(b.wdata));
        end
      end
      cyc++;
    end
  end

  // Writeback monitor
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!reset && rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rsp_unexpected: rd %0d data %0h, expected no response", rsp_rd, rsp_rdata);
        end else begin
          logic [36:0] e;
          e = exp_q.pop_front();
          check("rsp", 64'({rsp_rd, rsp_rdata}), 64'(e));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_wr = 1'b0; req_width = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    req_rd = 5'd0;
    r_req_valid = 1'b0; r_req_wr = 1'b0; r_req_width = 3'd0; r_req_addr = 32'h0;
    r_req_wdata = 32'h0; r_req_rd = 5'd0; r_data_gnt = 1'b1; r_data_valid = 1'b0;
    r_data_rdata = 32'h0;
    for (int a = 'h100; a < 'h148; a++) set_byte(32'(a), 8'($urandom));
    repeat (3) @(negedge clk);
    req_valid = 1'b1; req_width = 3'd2; req_addr = 32'h100;
    #3;
    check("reset_req_ready", 64'(req_ready), 64'd0);
    check("reset_data_req", 64'(data_req), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_err", 64'(rsp_err), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    req_valid = 1'b0;
    #3;
    check("post_reset_busy", 64'(busy), 64'd0);
    check("post_reset_state", 64'(dbg_state), 64'd0);

    // Reject-mode instance, single outstanding beat
    @(negedge clk);
    r_req_valid = 1'b1; r_req_width = 3'd2; r_req_addr = 32'h102; r_req_rd = 5'd6;
    #3;
    check("rej_data_req", 64'(r_data_req), 64'd0);
    check("rej_req_ready", 64'(r_req_ready), 64'd1);
    check("rej_rsp_err", 64'(r_rsp_err), 64'd1);
    @(negedge clk);
    r_req_valid = 1'b0;
    #3;
    check("rej_err_pulse", 64'(r_rsp_err), 64'd0);
    @(negedge clk);
    r_req_valid = 1'b1; r_req_addr = 32'h100; r_req_rd = 5'd7;
    #3;
    check("rej_aligned_req", 64'(r_data_req), 64'd1);
    check("rej_aligned_ready", 64'(r_req_ready), 64'd1);
    check("rej_aligned_err", 64'(r_rsp_err), 64'd0);
    @(negedge clk);
    r_req_addr = 32'h104; r_req_rd = 5'd8;
    #3;
    check("rej_full_stall", 64'(r_data_req), 64'd0);
    @(negedge clk);
    r_data_valid = 1'b1; r_data_rdata = 32'hCAFEF00D;
    #3;
    check("rej_issue_on_pop", 64'(r_data_req), 64'd1);
    check("rej_rsp_valid", 64'(r_rsp_valid), 64'd1);
    check("rej_rsp", 64'({r_rsp_rd, r_rsp_rdata}), 64'({5'd7, 32'hCAFEF00D}));
    @(negedge clk);
    r_req_valid = 1'b0; r_data_rdata = 32'h12345678;
    #3;
    check("rej_rsp2", 64'({r_rsp_rd, r_rsp_rdata}), 64'({5'd8, 32'h12345678}));
    @(negedge clk);
    r_data_valid = 1'b0;
    #3;
    check("rej_idle_busy", 64'(r_busy), 64'd0);

    // Directed accesses
    @(negedge clk);
    set_byte(32'h100, 8'hEF); set_byte(32'h101, 8'hBE);
    set_byte(32'h102, 8'hAD); set_byte(32'h103, 8'hDE);
    do_req(1'b0, 3'd2, 32'h100, 32'h0, 5'd9, 1'b1, 32'hDEADBEEF);
    drain();
    set_byte(32'h101, 8'h11); set_byte(32'h102, 8'h22);
    set_byte(32'h103, 8'h33); set_byte(32'h104, 8'h44);
    do_req(1'b0, 3'd2, 32'h101, 32'h0, 5'd10, 1'b1, 32'h44332211);
    drain();
    set_byte(32'h103, 8'h80); set_byte(32'h104, 8'hFF);
    do_req(1'b0, 3'b001, 32'h103, 32'h0, 5'd11, 1'b1, 32'hFFFFFF80);
    do_req(1'b0, 3'b101, 32'h103, 32'h0, 5'd12, 1'b1, 32'h0000FF80);
    do_req(1'b1, 3'd2, 32'h102, 32'h11223344, 5'd0);
    do_req(1'b0, 3'd2, 32'h100, 32'h0, 5'd13);
    do_req(1'b0, 3'd2, 32'h104, 32'h0, 5'd14);
    drain();

    // Three back-to-back byte loads against a full in-flight window
    hold_rsp = 1'b1;
    fork
      begin
        do_req(1'b0, 3'd0, 32'h120, 32'h0, 5'd1);
        do_req(1'b0, 3'd4, 32'h121, 32'h0, 5'd2);
        do_req(1'b0, 3'd0, 32'h122, 32'h0, 5'd3);
      end
      begin
        repeat (5) @(negedge clk);
        #3;
        check("full_stall_data_req", 64'(data_req), 64'd0);
        @(negedge clk);
        hold_rsp = 1'b0;
        #3;
        check("issue_on_pop", 64'(data_req), 64'd1);
      end
    join
    drain();

    // Randomized traffic
    gnt_always = 1'b0;
    repeat (150) begin
      logic [2:0] w;
      w = {1'($urandom), 2'($urandom_range(0, 2))};
      do_req(1'($urandom), w, 32'h100 + 32'($urandom_range(0, 63)), $urandom,
             5'($urandom));
      if ($urandom_range(0, 9) == 0) @(negedge clk);
    end
    drain();

    // Reset with a beat in flight and a split stalled in its second beat
    gnt_always = 1'b1;
    hold_rsp = 1'b1;
    do_req(1'b0, 3'd0, 32'h110, 32'h0, 5'd3);
    push_model(1'b0, 3'd2, 32'h111, 32'h0, 5'd4, 1'b0, 32'h0);
    req_valid = 1'b1; req_wr = 1'b0; req_width = 3'd2; req_addr = 32'h111; req_rd = 5'd4;
    repeat (4) @(negedge clk);
    #3;
    check("split_stall_busy", 64'(busy), 64'd1);
    check("split_stall_state", 64'(dbg_state), 64'd1);
    check("split_stall_data_req", 64'(data_req), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    exp_beat_q.delete();
    #3;
    check("midrst_req_ready", 64'(req_ready), 64'd0);
    check("midrst_data_req", 64'(data_req), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    req_valid = 1'b0;
    hold_rsp = 1'b0;
    #3;
    check("after_rst_busy", 64'(busy), 64'd0);
    check("after_rst_state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    drain();
    repeat (3) @(negedge clk);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    check("beat_q_empty", 64'(exp_beat_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
